pu_muldiv: RTL

//  Multi-cycle unsigned multiply/divide unit beside the PU ALU. Reads operands from

---
 rtl/pu_pkg.sv | 20 ++
 rtl/pu_muldiv_step.sv | 38 +++
 rtl/pu_muldiv.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pu_pkg.sv
// Shared types and default sizes for the PU multiply/divide unit.
package pu_pkg;

    localparam int unsigned PU_W   = 16;
    localparam int unsigned PU_RAW = 2;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIVU = 2'b01,
        MD_REMU = 2'b10,
        MD_NOP  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WB   = 2'b10
    } md_state_e;

endpackage

// File: rtl/pu_muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// hi holds the accumulator upper half / partial remainder, lo the multiplier / quotient.
module pu_muldiv_step
    import pu_pkg::*;
#(
    parameter int unsigned W = PU_W
) (
    input  logic         mul_i,
    input  logic [W:0]   hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   hi_c_o,
    output logic [W-1:0] lo_c_o
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] trial;
    logic       fits;

    always_comb begin
        sum     = {1'b0, hi_i[W-1:0]} + (lo_i[0] ? {1'b0, b_i} : (W+1)'(0));
        shifted = {hi_i[W-1:0], lo_i[W-1]};
        trial   = shifted - {1'b0, b_i};
        fits    = ~trial[W];
        hi_c_o  = '0;
        lo_c_o  = '0;
        if (mul_i) begin
            hi_c_o = {1'b0, sum[W:1]};
            lo_c_o = {sum[0], lo_i[W-1:1]};
        end else begin
            // Negative trial result means the divisor does not fit: restore.
            hi_c_o = fits ? trial : shifted;
            lo_c_o = {lo_i[W-2:0], fits};
        end
    end

endmodule

// File: rtl/pu_muldiv.sv
// Multi-cycle unsigned MUL/DIVU/REMU unit; one bit per cycle, single-cycle write-back pulse.
module pu_muldiv
    import pu_pkg::*;
#(
    parameter int unsigned W   = PU_W,
    parameter int unsigned RAW = PU_RAW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [RAW-1:0] rd,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           div0,
    output logic           we,
    output logic [RAW-1:0] wad,
    output logic [W-1:0]   wd
);

    localparam int unsigned CW = $clog2(W + 1);

    md_state_e      state_q, state_d;
    md_op_e         op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [W-1:0]   b_q, b_d;
    logic [W:0]     hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           div0_q, div0_d;
    logic           we_q, we_d;
    logic [RAW-1:0] wad_q, wad_d;
    logic [W-1:0]   wd_q, wd_d;

    logic [W:0]     hi_c;
    logic [W-1:0]   lo_c;

    pu_muldiv_step #(.W(W)) u_step (
        .mul_i  (op_q == MD_MUL),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .b_i    (b_q),
        .hi_c_o (hi_c),
        .lo_c_o (lo_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = div0_q;
        wad_d   = wad_q;
        wd_d    = wd_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (md_op_e'(op) != MD_NOP)) begin
                    state_d = S_RUN;
                    op_d    = md_op_e'(op);
                    rd_d    = rd;
                    b_d     = b;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a;
                    div0_d  = 1'b0;
                end
            end
            S_RUN: begin
                // W iterations run on cnt 0..W-1; cnt==W formats the result.
                if (cnt_q == CW'(W)) begin
                    state_d = S_WB;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    wad_d   = rd_q;
                    wd_d    = (op_q == MD_REMU) ? hi_q[W-1:0] : lo_q;
                    div0_d  = (op_q != MD_MUL) && (b_q == '0);
                end else begin
                    hi_d  = hi_c;
                    lo_d  = lo_c;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            rd_q    <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            we_q    <= 1'b0;
            wad_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            we_q    <= we_d;
            wad_q   <= wad_d;
            wd_q    <= wd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign we   = we_q;
    assign wad  = wad_q;
    assign wd   = wd_q;

endmodule
